exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle execution controller for the pico-MIPS core, placed between the instruction decoder and the PC/register-file enables. It stalls the PC and gates register write-back while a MULT waits on the iterative multiplier or a STIN/LOUT waits on its external I/O handshake. Single-cycle instructions pass through untouched.

## Interface
- `MULT_CYCLES`, default 8: cycles the iterative multiplier needs after `mult_start`. Legal range 1..255.
- `DATA_WIDTH`, default 8: width of the I/O data path.
- `clk` in 1: system clock, rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `mult` in 1: decoded MULT.
- `read_in` in 1: decoded STIN.
- `write_out` in 1: decoded LOUT.
- `reg_write` in 1: decoded register-write request.
- `reg_data` in DATA_WIDTH: register-file read value (LOUT source).
- `in_data` in DATA_WIDTH: external input word.
- `in_valid` in 1: external input word valid.
- `in_ready` out 1: sequencer accepting input.
- `out_ready` in 1: external sink accepting output.
- `out_valid` out 1: `out_data` valid.
- `out_data` out DATA_WIDTH: registered output word.
- `in_word` out DATA_WIDTH: registered captured input, the STIN write-back source.
- `mult_start` out 1: one-cycle multiplier start pulse.
- `pc_en` out 1: advance the PC this cycle.
- `reg_we` out 1: gated register-file write enable.
- `busy` out 1: sequencer is in any state other than EXEC.

## Operation
- States: EXEC, MULT_WAIT, IN_WAIT, IN_WB, OUT_WAIT.
- EXEC:
  - If `mult`: `mult_start`=1, `pc_en`=0, `reg_we`=0. Load the counter with MULT_CYCLES-1. Next state MULT_WAIT.
  - Else if `read_in`: `pc_en`=0, `reg_we`=0. Next state IN_WAIT.
  - Else if `write_out`: `out_data`<=`reg_data`, `pc_en`=0. Next state OUT_WAIT.
  - Otherwise: `pc_en`=1, `reg_we`=`reg_write`. Stay in EXEC.
- Priority when several decode flags are high (illegal, but defined): `mult` > `read_in` > `write_out`.
- MULT_WAIT:
  - Counter decrements each cycle.
  - When the counter is 0: `reg_we`=1, `pc_en`=1, next state EXEC.
  - Otherwise `pc_en`=0, `reg_we`=0.
- IN_WAIT:
  - `in_ready`=1.
  - On `in_valid`: `in_word`<=`in_data`, next state IN_WB.
  - Otherwise stay.
- IN_WB: `reg_we`=1, `pc_en`=1, next state EXEC. `in_ready`=0.
- OUT_WAIT:
  - `out_valid`=1. `out_data` is held stable.
  - On `out_ready`: `pc_en`=1, next state EXEC.
  - Otherwise stay with `pc_en`=0.
- While `pc_en`=0 the decode inputs are required to stay stable, since instruction fetch is combinational on the PC. The sequencer ignores decode-input changes outside EXEC.
- Counter width is `$clog2(MULT_CYCLES+1)`, minimum 1. It never wraps, because it is only decremented while non-zero.

## Timing
- Reset values:
  - state EXEC, counter 0, `in_word` 0, `out_data` 0.
  - `mult_start`, `in_ready`, `out_valid` and `busy` are all 0.
  - `pc_en` and `reg_we` follow the EXEC rules.
- Reset is asynchronous and may be asserted mid-operation: it aborts any wait immediately, with no write-back and no PC advance pending.
- Instruction occupancy:
  - Single-cycle ops: 1 cycle.
  - MULT: exactly MULT_CYCLES+1 cycles. `mult_start` is high in cycle 0; `reg_we` is high in the last cycle.
  - STIN: 2 cycles plus the number of IN_WAIT cycles, minimum 3.
  - LOUT: 1 cycle plus the number of OUT_WAIT cycles, minimum 2.
- Handshakes:
  - Transfer occurs when valid and ready are both high at a clock edge.
  - `in_ready` and `out_valid` are Moore outputs (functions of state only).
  - `in_valid` already high on entry to IN_WAIT is accepted on the first IN_WAIT edge. Same rule for `out_ready` in OUT_WAIT.
- No combinational path from `in_valid` or `out_ready` to `in_ready` or `out_valid`.

## Structure
- State enum `seq_state_t` lives in shared package `seq_pkg`, together with `SEQ_CNT_W(n)`, the counter-width helper.
- Single module, no sub-modules: one `always_ff` for state, counter and data registers, one `always_comb` for next state and outputs.

## Test plan
- Reset, then `reg_write`=1 with no multi-cycle flag → `pc_en`=1 and `reg_we`=1 every cycle; `busy`=0.
- `mult`=1 with MULT_CYCLES=8 → `mult_start` pulses in cycle 0; `pc_en`=0 in cycles 0–7; `pc_en`=1 and `reg_we`=1 in cycle 8 only.
- `read_in`=1, then `in_valid` delayed 5 cycles with `in_data`=0xA5 → `in_word`=0xA5; `reg_we`=1 in the cycle after capture; total 8 cycles.
- `write_out`=1 with `reg_data`=0x3C and `out_ready` held low for 4 cycles → `out_data`=0x3C stable and `out_valid`=1 for 5 cycles; `pc_en` pulses once on the accept.
- `mult`, `read_in` and `write_out` all high → MULT path taken, no `in_ready` or `out_valid` asserted.
- `n_reset` low in the 3rd MULT_WAIT cycle → immediate return to EXEC with all outputs at their reset values; no `reg_we` pulse after release.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and helpers for the pico-MIPS multi-cycle execution sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        EXEC      = 3'd0,
        MULT_WAIT = 3'd1,
        IN_WAIT   = 3'd2,
        IN_WB     = 3'd3,
        OUT_WAIT  = 3'd4
    } seq_state_t;

    // Counter width able to hold n, never narrower than one bit.
    function automatic int SEQ_CNT_W(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/exec_sequencer.sv
// Multi-cycle execution controller: stalls the PC and gates register write-back
// while MULT waits on the multiplier or STIN/LOUT wait on their I/O handshake.
module exec_sequencer
    import seq_pkg::*;
#(
    parameter int MULT_CYCLES = 8,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  mult,
    input  logic                  read_in,
    input  logic                  write_out,
    input  logic                  reg_write,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] in_word,
    output logic                  mult_start,
    output logic                  pc_en,
    output logic                  reg_we,
    output logic                  busy
);

    localparam int CNT_W = SEQ_CNT_W(MULT_CYCLES);

    seq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] in_word_q, in_word_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // State, multiplier countdown and captured I/O words.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= EXEC;
            cnt_q      <= {CNT_W{1'b0}};
            in_word_q  <= {DATA_WIDTH{1'b0}};
            out_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_word_q  <= in_word_d;
            out_data_q <= out_data_d;
        end
    end

    // Next state and outputs; in_ready/out_valid/busy depend on state only.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_word_d  = in_word_q;
        out_data_d = out_data_q;
        mult_start = 1'b0;
        pc_en      = 1'b0;
        reg_we     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_q)
            EXEC: begin
                busy = 1'b0;
                if (mult) begin
                    mult_start = 1'b1;
                    cnt_d      = CNT_W'(MULT_CYCLES - 1);
                    state_d    = MULT_WAIT;
                end else if (read_in) begin
                    state_d = IN_WAIT;
                end else if (write_out) begin
                    out_data_d = reg_data;
                    state_d    = OUT_WAIT;
                end else begin
                    pc_en  = 1'b1;
                    reg_we = reg_write;
                end
            end
            // The counter only moves while non-zero, so it can never wrap.
            MULT_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    pc_en   = 1'b1;
                    reg_we  = 1'b1;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IN_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_word_d = in_data;
                    state_d   = IN_WB;
                end else begin
                    state_d = IN_WAIT;
                end
            end
            IN_WB: begin
                pc_en   = 1'b1;
                reg_we  = 1'b1;
                state_d = EXEC;
            end
            OUT_WAIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pc_en   = 1'b1;
                    state_d = EXEC;
                end else begin
                    state_d = OUT_WAIT;
                end
            end
            default: begin
                state_d = EXEC;
            end
        endcase
    end

    assign out_data = out_data_q;
    assign in_word  = in_word_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized self-checking bench for exec_sequencer against an instruction-level model.
module tb_exec_sequencer;

    localparam int MC = 8;
    localparam int DW = 8;

    localparam int OP_SINGLE = 0;
    localparam int OP_MULT   = 1;
    localparam int OP_IN     = 2;
    localparam int OP_OUT    = 3;
    localparam int OP_ALL    = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          mult, read_in, write_out, reg_write;
    logic [DW-1:0] reg_data, in_data;
    logic          in_valid, in_ready, out_ready, out_valid;
    logic [DW-1:0] out_data, in_word;
    logic          mult_start, pc_en, reg_we, busy;

    logic [DW-1:0] m_in_word;
    logic [DW-1:0] m_out_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exec_sequencer #(.MULT_CYCLES(MC), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .mult       (mult),
        .read_in    (read_in),
        .write_out  (write_out),
        .reg_write  (reg_write),
        .reg_data   (reg_data),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .in_word    (in_word),
        .mult_start (mult_start),
        .pc_en      (pc_en),
        .reg_we     (reg_we),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all(input logic e_ms, input logic e_pc, input logic e_we,
                             input logic e_ir, input logic e_ov, input logic e_busy);
        check_val("mult_start", 32'(mult_start), 32'(e_ms));
        check_val("pc_en",      32'(pc_en),      32'(e_pc));
        check_val("reg_we",     32'(reg_we),     32'(e_we));
        check_val("in_ready",   32'(in_ready),   32'(e_ir));
        check_val("out_valid",  32'(out_valid),  32'(e_ov));
        check_val("busy",       32'(busy),       32'(e_busy));
        check_val("in_word",    32'(in_word),    32'(m_in_word));
        check_val("out_data",   32'(out_data),   32'(m_out_data));
    endtask

    // One whole instruction: occupancy and per-cycle outputs follow from the op's cycle index.
    task automatic run_instr(input int op, input int dly, input logic [DW-1:0] rdata,
                             input logic rw, input logic [DW-1:0] idata);
        int len;
        logic e_ms, e_pc, e_we, e_ir, e_ov;
        case (op)
            OP_SINGLE: len = 1;
            OP_IN:     len = dly + 3;
            OP_OUT:    len = dly + 2;
            default:   len = MC + 1;
        endcase
        mult      = (op == OP_MULT) || (op == OP_ALL);
        read_in   = (op == OP_IN)   || (op == OP_ALL);
        write_out = (op == OP_OUT)  || (op == OP_ALL);
        reg_write = rw;
        reg_data  = rdata;
        for (int k = 0; k < len; k++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_data   = DW'($urandom);
            if (op == OP_IN && k >= 1) in_valid = (k - 1 >= dly);
            if (op == OP_OUT && k >= 1) out_ready = (k - 1 >= dly);
            if (op == OP_IN && k == dly + 1) in_data = idata;
            e_ms = 1'b0; e_pc = 1'b0; e_we = 1'b0; e_ir = 1'b0; e_ov = 1'b0;
            case (op)
                OP_SINGLE: begin e_pc = 1'b1; e_we = rw; end
                OP_IN: begin
                    e_ir = (k >= 1) && (k <= dly + 1);
                    e_pc = (k == dly + 2);
                    e_we = (k == dly + 2);
                end
                OP_OUT: begin
                    e_ov = (k >= 1);
                    e_pc = (k == dly + 1);
                end
                default: begin
                    e_ms = (k == 0);
                    e_pc = (k == MC);
                    e_we = (k == MC);
                end
            endcase
            @(negedge clk);
            check_all(e_ms, e_pc, e_we, e_ir, e_ov, (k > 0));
            @(posedge clk);
            if (op == OP_IN && k == dly + 1) m_in_word = idata;
            if (op == OP_OUT && k == 0) m_out_data = rdata;
            #1;
        end
    endtask

    initial begin
        n_reset   = 1'b0;
        mult      = 1'b0;
        read_in   = 1'b0;
        write_out = 1'b0;
        reg_write = 1'b0;
        reg_data  = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_in_word  = '0;
        m_out_data = '0;

        @(negedge clk);
        check_all(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;

        // Directed cases from the test plan.
        for (int i = 0; i < 3; i++) run_instr(OP_SINGLE, 0, 8'h11, 1'b1, 8'h00);
        run_instr(OP_MULT, 0, 8'h22, 1'b1, 8'h00);
        run_instr(OP_IN, 5, 8'h00, 1'b0, 8'hA5);
        run_instr(OP_OUT, 4, 8'h3C, 1'b0, 8'h00);
        run_instr(OP_ALL, 0, 8'h5A, 1'b1, 8'h00);
        run_instr(OP_IN, 0, 8'h00, 1'b1, 8'h7E);
        run_instr(OP_OUT, 0, 8'hC3, 1'b0, 8'h00);

        // Randomized instruction stream.
        for (int i = 0; i < 80; i++) begin
            int op;
            op = int'($urandom_range(0, 4));
            run_instr(op, int'($urandom_range(0, 4)), DW'($urandom),
                      (op == OP_OUT) ? 1'b0 : 1'($urandom), DW'($urandom));
        end

        // Reset during the third MULT_WAIT cycle.
        mult      = 1'b1;
        read_in   = 1'b0;
        write_out = 1'b0;
        reg_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        check_val("busy_pre_rst", 32'(busy), 32'(1'b1));
        #2;
        n_reset   = 1'b0;
        mult      = 1'b0;
        reg_write = 1'b0;
        m_in_word  = '0;
        m_out_data = '0;
        #1;
        check_all(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_all(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
